// File: rtl/hfrv_mem_responder.sv
// hfrv_mem_responder: word-organised RAM answering HF-RISC data-bus accesses.
// Optional wait-state FSM enabled by defining HFRV_MEM_WAIT_STATES_EN; without it
// every access completes in the cycle it is presented and stall is tied low.
module hfrv_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_access,
  input  logic [31:0] address,
  input  logic [31:0] data_write,
  input  logic [3:0]  data_we,
  output logic [31:0] data_read,
  output logic        stall,
  output logic        err
);

  localparam int          AW    = $clog2(DEPTH);
  // One past the last byte of the window, in 33 bits so the compare never wraps.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  // The access being completed this cycle (live inputs or latched copy).
  logic        commit;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_we;

`ifdef HFRV_MEM_WAIT_STATES_EN
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  we_q, we_d;

  // State, counter and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, complete at count 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    commit  = 1'b0;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_we    = we_q;
    case (state_q)
      IDLE: begin
        if (data_access) begin
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            c_addr  = address;
            c_wdata = data_write;
            c_we    = data_we;
          end else begin
            addr_d  = address;
            wdata_d = data_write;
            we_d    = data_we;
            cnt_d   = WAIT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = (state_q == BUSY);
`else
  // Wait-state count has no meaning in the zero-wait build.
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);

  assign commit  = data_access;
  assign c_addr  = address;
  assign c_wdata = data_write;
  assign c_we    = data_we;
  assign stall   = 1'b0;
`endif

  logic [31:0]   offset;
  logic          hit;
  logic [AW-1:0] idx;
  logic          commit_ok;
  logic          wr_hit;
  logic          rd_hit;
  logic          rd_miss;
  logic          err_d, err_q;
  logic          unused_bits;

  // Window decode and per-access strobes; reset suppresses any completion.
  always_comb begin
    offset    = c_addr - BASE_ADDR;
    hit       = ({1'b0, c_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, c_addr} < LIMIT);
    idx       = offset[AW+1:2];
    commit_ok = commit && !reset;
    wr_hit    = commit_ok && hit && (c_we != 4'b0000);
    rd_hit    = commit_ok && hit && (c_we == 4'b0000);
    rd_miss   = commit_ok && !hit && (c_we == 4'b0000);
    err_d     = commit_ok && !hit;
  end

  assign unused_bits = ^{offset[31:AW+2], offset[1:0]};

  // Error pulse register: high for the one cycle after a missed access completes.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;

  // One byte-wide RAM and read register per lane so byte enables map directly.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Lane write port; contents are never cleared.
    always_ff @(posedge clk) begin
      if (wr_hit && c_we[gi]) mem[idx] <= c_wdata[8*gi +: 8];
    end

    // Registered lane read; holds between reads, zero on a missed read.
    always_ff @(posedge clk) begin
      if (reset)        rd_q <= '0;
      else if (rd_hit)  rd_q <= mem[idx];
      else if (rd_miss) rd_q <= '0;
    end

    assign data_read[8*gi +: 8] = rd_q;
  end

endmodule

// File: doc/hfrv_mem_responder.md
# hfrv_mem_responder

Synthesizable memory-side responder for the HF-RISC data bus. It answers CPU data accesses (`data_access`, `address`, `data_write`, `data_we`) from an internal word-organised RAM and returns read data on `data_read`. It can insert wait states through `stall`, and it flags accesses outside its window. It sits between the CPU's bus outputs and the `stall`/`data_read` inputs, and stands in for the behavioural memory in system-level benches.

## Interface
Parameters:
- `BASE_ADDR`, 32'h4000_0000: byte address of word 0; must be 4-byte aligned.
- `DEPTH`, 1024: number of 32-bit words; power of two, range 16..65536.
- `WAIT_CYCLES`, 2: stall cycles inserted per access; only used with `HFRV_MEM_WAIT_STATES_EN`; range 0..15.

Ports:
- `clk` in 1: single clock; all logic samples on its rising edge.
- `reset` in 1: synchronous, active-high.
- `data_access` in 1: CPU access request, valid this cycle.
- `address` in 32: byte address; bits [1:0] ignored.
- `data_write` in 32: write data.
- `data_we` in 4: byte write enables; bit i covers bits [8i+7:8i]; all-zero means read.
- `data_read` out 32: registered read data.
- `stall` out 1: holds the CPU while a wait-stated access is in progress.
- `err` out 1: one-cycle pulse on an out-of-window access.

## Operation
- Window hit: `BASE_ADDR <= address < BASE_ADDR + 4*DEPTH`, using unsigned 32-bit compare with no wrap. Word index is `(address - BASE_ADDR) >> 2`, truncated to log2(DEPTH) bits.
- Write: only bytes whose `data_we` bit is set change; the other bytes keep their old value. `data_read` is not updated by writes.
- Read: `data_read` takes `mem[index]`. Between reads, `data_read` holds its last value.
- Miss: a write is dropped; a read loads 32'h0 into `data_read`. `err` pulses high for 1 cycle at the same edge the response completes.
- RAM contents are not initialised and are not affected by `reset`.
- State machine, wait-state build only:
  - IDLE: `data_access`=1 → latch the address, data and enables, load the counter with `WAIT_CYCLES`, go to BUSY. If `WAIT_CYCLES`=0, complete immediately as in the zero-wait build.
  - BUSY: decrement the counter each cycle while `data_access` is ignored. At counter==1, commit the write or load `data_read`, raise `err` if it was a miss, and return to IDLE.
- Zero-wait build: no FSM; every cycle with `data_access`=1 completes in that cycle.

## Timing
- Reset values: `data_read`=0, `stall`=0, `err`=0, FSM=IDLE, counter=0.
- Zero-wait read latency: access sampled at edge N gives `data_read` valid after edge N. The CPU samples it in cycle N+1.
- Zero-wait write: visible to a read sampled at the next edge; back-to-back write→read of the same word returns the new data.
- Wait-state build:
  - `stall` is high from the cycle after the accepting edge for exactly `WAIT_CYCLES` cycles, and is driven combinationally from the state (high in BUSY).
  - Read data becomes valid at the edge where `stall` falls.
  - Accesses are back-to-back: a new request seen in IDLE right after BUSY is accepted at once.
  - The CPU holds its request stable while `stall`=1; the responder uses the latched copy regardless.
- `reset` asserted mid-BUSY: the pending write is discarded, FSM→IDLE, and all outputs return to reset values on the next edge.
- `reset` and `data_access` in the same cycle: `reset` wins and the access is ignored.
- `err` is never high for two consecutive cycles from a single access.

## Configuration
- `HFRV_MEM_WAIT_STATES_EN` defined: the IDLE/BUSY FSM and counter are built, `stall` behaves as above, and `WAIT_CYCLES` applies.
- Undefined: `stall` is tied to 0, there is no FSM or counter, all accesses are zero-wait, and `WAIT_CYCLES` is ignored.

## Test plan
- Reset with outputs forced busy → after 1 edge, `data_read`=0, `stall`=0, `err`=0.
- Zero-wait: write 32'hDEAD_BEEF, we=4'hF at 0x4000_0010, then read it → `data_read`=32'hDEAD_BEEF one cycle after the read; `err` stays 0.
- Byte lanes: word holds 32'h1122_3344; write 32'hAABB_CCDD with we=4'b0101 → read returns 32'h11BB_33DD.
- Miss: read 0x3FFF_FFFC, then write 0x4000_1000 with DEPTH=1024 → `data_read`=0, `err` pulses one cycle per access, and RAM is unchanged (re-read of 0x4000_0FFC returns its prior value).
- Wait states (macro on, WAIT_CYCLES=2): read of a word holding 32'h0000_00A5 → `stall` high exactly 2 cycles, and `data_read`=32'h0000_00A5 at the edge `stall` falls. A second back-to-back read stalls 2 more cycles.
- Reset mid-BUSY: a write of 32'h5555_5555 to a word holding 32'h0 is aborted by `reset` in its first stall cycle → `stall`=0 next cycle, and a later read returns 32'h0.
